// File: rtl/down_counter.sv
// ---------------------------------------------------------------------------
// down_counter
//
// Loadable down-counter timer. A start value is loaded on i_start, the count
// decrements once per clock to zero, and o_done pulses for one cycle when
// zero is reached. i_hold freezes the count (PAUSED) and i_stop aborts it.
//
// Optional feature: define DOWN_COUNTER_RELOAD_EN for periodic operation.
// The last loaded start value is kept in a reload register. On reaching zero
// the counter stays in RUN, spends one cycle at zero, then reloads. It keeps
// doing this until stop, start or reset. With the macro undefined the counter
// is one-shot and no reload register exists.
//
// Ports
//   i_clk          clock; all state changes on the rising edge
//   i_reset        synchronous reset, active low
//   i_start        load i_start_value and begin counting (highest priority)
//   i_start_value  value loaded on i_start (WIDTH bits)
//   i_hold         freeze the count while high
//   i_stop         abort a count in RUN/PAUSED, return to IDLE with out = 0
//   o_out          current count, registered
//   o_is_zero      combinational, o_out == 0
//   o_done         registered one-cycle pulse on reaching zero
//   o_busy         state is RUN or PAUSED
//   o_paused       state is PAUSED
// ---------------------------------------------------------------------------
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_start_value,
  input  logic             i_hold,
  input  logic             i_stop,
  output logic [WIDTH-1:0] o_out,
  output logic             o_is_zero,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_paused
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_done;

`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
`endif

  // Result of one counting step, used from RUN and on release from PAUSED
  // (the release edge also counts, so there is no bubble cycle).
  logic [WIDTH-1:0] w_dec_out;
  logic             w_dec_done;
  logic [1:0]       w_dec_state;

  always_comb begin
    w_dec_out   = r_out - WIDTH'(1);
    w_dec_done  = 1'b0;
    w_dec_state = S_RUN;
    if (r_out == WIDTH'(1)) begin
      w_dec_out  = '0;
      w_dec_done = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
      w_dec_state = S_RUN;
`else
      w_dec_state = S_IDLE;
`endif
    end else if (r_out == '0) begin
      // Never decrement from zero. With reload this is the zero cycle of a
      // periodic run; without reload it is unreachable but kept safe.
`ifdef DOWN_COUNTER_RELOAD_EN
      w_dec_out   = r_reload;
      w_dec_state = S_RUN;
`else
      w_dec_out   = '0;
      w_dec_state = S_IDLE;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_done  <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      // done is a pulse: cleared unless set below
      r_done <= 1'b0;
      if (i_start) begin
        r_out <= i_start_value;
`ifdef DOWN_COUNTER_RELOAD_EN
        r_reload <= i_start_value;
`endif
        // A zero load completes immediately; a restart of a running count
        // never pulses done by itself.
        if (i_start_value != '0) begin
          r_state <= S_RUN;
        end else begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      end else if (i_stop && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_out   <= '0;
      end else begin
        case (r_state)
          S_RUN, S_PAUSED: begin
            if (i_hold) begin
              r_state <= S_PAUSED;
            end else begin
              r_out   <= w_dec_out;
              r_done  <= w_dec_done;
              r_state <= w_dec_state;
            end
          end
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_out     = r_out;
  assign o_is_zero = (r_out == '0);
  assign o_done    = r_done;
  assign o_busy    = (r_state == S_RUN) || (r_state == S_PAUSED);
  assign o_paused  = (r_state == S_PAUSED);

endmodule
